// File: rtl/srsystem_tx_framer_if.sv
// Load handshake bundle between a byte producer and srsystem_tx_framer.
// The producer drives ld/d/opn; the framer answers with rdy.
interface srsystem_tx_framer_if;
  logic       ld;
  logic [7:0] d;
  logic       opn;
  logic       rdy;

  modport master (output ld, output d, output opn, input rdy);
  modport slave  (input ld, input d, input opn, output rdy);
endinterface

// File: rtl/srsystem_tx_framer.sv
// Serial transmit framer: serialises one byte per load into an 11-bit
// LSB-first frame start(0), d[0..7], parity, stop(1); line idles at mark.
// Bit periods last DIV cycles in which en=1; en=0 freezes everything.
// Optional build macro SRT_TX_HOLD_EN adds a one-entry {opn,d} holding
// register so a second byte can be queued and sent with no mark gap.
module srsystem_tx_framer #(
  parameter int unsigned DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  srsystem_tx_framer_if.slave  ld_bus,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  // Parity bit that makes data plus parity odd (odd=1) or even (odd=0).
  function automatic logic frame_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [3:0] idx_r, idx_s;
  logic [7:0] sr_r, sr_s;
  logic       par_r, par_s;
  logic       tx_r, tx_s;
  logic       done_r, done_s;
  logic       rdy_r, rdy_s;
  logic       busy_r, busy_s;
  logic       accept_s;
  logic       tick_s;
  logic       load_s;
  logic [7:0] load_d_s;
  logic       load_opn_s;
`ifdef SRT_TX_HOLD_EN
  logic [7:0] hold_d_r, hold_d_s;
  logic       hold_opn_r, hold_opn_s;
  logic       hold_full_r, hold_full_s;
`endif

  assign accept_s   = ld_bus.ld & rdy_r;
  assign tick_s     = en & (cnt_r == DIV_LAST);
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign ld_bus.rdy = rdy_r;

  // Next-state, divider, shifter and registered-output decode.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    sr_s       = sr_r;
    par_s      = par_r;
    tx_s       = tx_r;
    done_s     = 1'b0;
    load_s     = 1'b0;
    load_d_s   = ld_bus.d;
    load_opn_s = ld_bus.opn;
`ifdef SRT_TX_HOLD_EN
    hold_d_s    = hold_d_r;
    hold_opn_s  = hold_opn_r;
    hold_full_s = hold_full_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_s = ST_DATA;
          idx_s   = 4'd0;
          tx_s    = sr_r[0];
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (idx_r == 4'd7) begin
            state_s = ST_PARITY;
            tx_s    = par_r;
          end else begin
            idx_s = idx_r + 4'd1;
            sr_s  = {1'b0, sr_r[7:1]};
            tx_s  = sr_r[1];
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s) begin
          state_s = ST_STOP;
          tx_s    = 1'b1;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          done_s = 1'b1;
          tx_s   = 1'b1;
`ifdef SRT_TX_HOLD_EN
          // A queued byte chains straight into the next start bit.
          if (hold_full_r) begin
            load_s      = 1'b1;
            load_d_s    = hold_d_r;
            load_opn_s  = hold_opn_r;
            hold_full_s = 1'b0;
          end else if (accept_s) begin
            load_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
`else
          state_s = ST_IDLE;
`endif
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        tx_s    = 1'b1;
      end
    endcase

    // Loading restarts the divider; otherwise it runs only inside a frame.
    if (load_s) begin
      state_s = ST_START;
      sr_s    = load_d_s;
      par_s   = frame_parity(load_d_s, load_opn_s);
      tx_s    = 1'b0;
      idx_s   = 4'd0;
      cnt_s   = 8'd0;
    end else if (state_r == ST_IDLE) begin
      cnt_s = 8'd0;
    end else if (en) begin
      cnt_s = tick_s ? 8'd0 : (cnt_r + 8'd1);
    end else begin
      cnt_s = cnt_r;
    end

`ifdef SRT_TX_HOLD_EN
    // Mid-frame accept parks the byte; stop-end accepts were loaded above.
    if (accept_s && (state_r != ST_IDLE) && !((state_r == ST_STOP) && tick_s)) begin
      hold_d_s    = ld_bus.d;
      hold_opn_s  = ld_bus.opn;
      hold_full_s = 1'b1;
    end else begin
      hold_full_s = hold_full_s;
    end
    rdy_s  = ~hold_full_s;
    busy_s = (state_s != ST_IDLE);
`else
    rdy_s  = (state_s == ST_IDLE);
    busy_s = ~rdy_s;
`endif
  end

  // Frame state, divider, shifter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      idx_r   <= 4'd0;
      sr_r    <= 8'd0;
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
      done_r  <= 1'b0;
      rdy_r   <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      sr_r    <= sr_s;
      par_r   <= par_s;
      tx_r    <= tx_s;
      done_r  <= done_s;
      rdy_r   <= rdy_s;
      busy_r  <= busy_s;
    end
  end

`ifdef SRT_TX_HOLD_EN
  // One-entry holding register for the queued byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_d_r    <= 8'd0;
      hold_opn_r  <= 1'b0;
      hold_full_r <= 1'b0;
    end else begin
      hold_d_r    <= hold_d_s;
      hold_opn_r  <= hold_opn_s;
      hold_full_r <= hold_full_s;
    end
  end
`endif

endmodule

// File: tb/tb_srsystem_tx_framer.sv
// Self-checking bench for srsystem_tx_framer (DIV=4). Expected line
// waveforms come from a frame model: the bit shown in a cycle is the
// frame bit selected by (enabled edges since accept)/DIV.
module tb_srsystem_tx_framer;
  localparam int DIV  = 4;
  localparam int MAXC = 400;
`ifdef SRT_TX_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic tx, busy, done;

  srsystem_tx_framer_if bus();

  srsystem_tx_framer #(.DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .ld_bus (bus),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  logic cap_tx   [0:MAXC];
  logic cap_en   [0:MAXC];
  logic cap_rdy  [0:MAXC];
  logic cap_busy [0:MAXC];
  int   done_cyc;

  // Frame bit idx (0=start, 1..8=data, 9=parity, 10=stop) from first principles.
  function automatic logic model_bit(input logic [7:0] data, input logic odd, input int idx);
    int ones;
    ones = $countones(data);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return data[idx-1];
    if (idx == 9) return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  // Cycle in which done should pulse: first cycle after 11*DIV enabled edges.
  function automatic int model_done();
    int n;
    int lim;
    n   = 0;
    lim = (done_cyc > 0) ? done_cyc : MAXC;
    for (int k = 1; k <= lim; k++) begin
      if (n == 11 * DIV) return k;
      n += cap_en[k] ? 1 : 0;
    end
    return -2;
  endfunction

  // Number of captured cycles whose tx disagrees with the frame model.
  function automatic int tx_errs(input logic [7:0] data, input logic odd);
    int   n, errs, lim, idx;
    logic exp_b;
    n    = 0;
    errs = 0;
    lim  = (done_cyc > 0) ? done_cyc : MAXC;
    for (int k = 1; k <= lim; k++) begin
      idx   = n / DIV;
      exp_b = (idx >= 11) ? 1'b1 : model_bit(data, odd, idx);
      if (cap_tx[k] !== exp_b) errs++;
      n += cap_en[k] ? 1 : 0;
    end
    return errs;
  endfunction

  // Cycles inside the frame where busy/rdy differ from the in-frame values.
  function automatic int flag_errs();
    int errs;
    int lim;
    errs = 0;
    lim  = (done_cyc > 0) ? done_cyc - 1 : MAXC;
    for (int k = 1; k <= lim; k++) begin
      if (cap_busy[k] !== 1'b1) errs++;
      if (cap_rdy[k] !== HOLD) errs++;
    end
    return errs;
  endfunction

  // Load one byte (call away from posedge) and capture until done or budget.
  // en_mode 0: en=1, 1: en high on even edges only, 2: random en.
  task automatic drive_frame(input logic [7:0] data, input logic odd, input int en_mode,
                             input int inj_k, input logic [7:0] inj_d);
    bus.ld  = 1'b1;
    bus.d   = data;
    bus.opn = odd;
    en      = 1'b1;
    @(posedge clk);
    done_cyc = -1;
    for (int k = 1; k <= MAXC; k++) begin
      @(negedge clk);
      bus.ld      = 1'b0;
      bus.d       = 8'($urandom);
      bus.opn     = 1'($urandom);
      cap_tx[k]   = tx;
      cap_rdy[k]  = bus.rdy;
      cap_busy[k] = busy;
      cap_en[k]   = 1'b1;
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
      if (k == inj_k) begin
        bus.ld = 1'b1;
        bus.d  = inj_d;
      end
      case (en_mode)
        0:       en = 1'b1;
        1:       en = ((k % 2) == 0);
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      cap_en[k] = en;
    end
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; bus.ld = 1'b0; bus.d = 8'h00; bus.opn = 1'b0;
    repeat (3) @(negedge clk);
    assert_cnt++; if (tx !== 1'b1)      begin fail_cnt++; $display("FAIL reset_tx got %b want 1", tx); end
    assert_cnt++; if (bus.rdy !== 1'b1) begin fail_cnt++; $display("FAIL reset_rdy got %b want 1", bus.rdy); end
    assert_cnt++; if (busy !== 1'b0)    begin fail_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
    assert_cnt++; if (done !== 1'b0)    begin fail_cnt++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    assert_cnt++; if (tx !== 1'b1) begin fail_cnt++; $display("FAIL idle_tx got %b want 1", tx); end
  endtask

  task automatic test_frame_basic();
    logic [10:0] tab;
    int          e;
    tab = 11'b11101001010;
    drive_frame(8'hA5, 1'b1, 0, 0, 8'h00);
    assert_cnt++; if (done_cyc !== 45) begin fail_cnt++; $display("FAIL a5_done_cycle got %0d want 45", done_cyc); end
    e = 0;
    for (int i = 0; i < 11; i++) if (cap_tx[2 + 4 * i] !== tab[i]) e++;
    assert_cnt++; if (e !== 0) begin fail_cnt++; $display("FAIL a5_bit_table got %0d bad bits want 0", e); end
    e = tx_errs(8'hA5, 1'b1);
    assert_cnt++; if (e !== 0) begin fail_cnt++; $display("FAIL a5_tx_wave got %0d bad cycles want 0", e); end
    assert_cnt++; if (cap_rdy[45] !== 1'b1) begin fail_cnt++; $display("FAIL a5_rdy_at_done got %b want 1", cap_rdy[45]); end
    assert_cnt++; if (cap_busy[45] !== 1'b0) begin fail_cnt++; $display("FAIL a5_busy_at_done got %b want 0", cap_busy[45]); end
    e = flag_errs();
    assert_cnt++; if (e !== 0) begin fail_cnt++; $display("FAIL a5_flags got %0d bad cycles want 0", e); end
  endtask

  task automatic test_parity();
    repeat (2) @(negedge clk);
    drive_frame(8'h00, 1'b0, 0, 0, 8'h00);
    assert_cnt++; if (cap_tx[38] !== 1'b0) begin fail_cnt++; $display("FAIL par_00_even got %b want 0", cap_tx[38]); end
    drive_frame(8'h01, 1'b0, 0, 0, 8'h00);
    assert_cnt++; if (cap_tx[38] !== 1'b1) begin fail_cnt++; $display("FAIL par_01_even got %b want 1", cap_tx[38]); end
    assert_cnt++; if (tx_errs(8'h01, 1'b0) !== 0) begin fail_cnt++; $display("FAIL par_01_wave got %0d want 0", tx_errs(8'h01, 1'b0)); end
  endtask

  task automatic test_en_toggle();
    int e;
    repeat (2) @(negedge clk);
    drive_frame(8'h5A, 1'b0, 1, 0, 8'h00);
    assert_cnt++; if (done_cyc - 1 !== 88) begin fail_cnt++; $display("FAIL entog_len got %0d want 88", done_cyc - 1); end
    e = tx_errs(8'h5A, 1'b0);
    assert_cnt++; if (e !== 0) begin fail_cnt++; $display("FAIL entog_wave got %0d bad cycles want 0", e); end
    repeat (2) @(negedge clk);
    drive_frame(8'($urandom), 1'b1, 2, 0, 8'h00);
    assert_cnt++; if (done_cyc !== model_done()) begin fail_cnt++; $display("FAIL enrand_done got %0d want %0d", done_cyc, model_done()); end
  endtask

  task automatic test_ld_ignored();
    int e;
    repeat (2) @(negedge clk);
    drive_frame(8'h96, 1'b1, 0, 10, 8'hFF);
    assert_cnt++; if (done_cyc !== 45) begin fail_cnt++; $display("FAIL ign_done got %0d want 45", done_cyc); end
    e = tx_errs(8'h96, 1'b1);
    assert_cnt++; if (e !== 0) begin fail_cnt++; $display("FAIL ign_wave got %0d bad cycles want 0", e); end
    e = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) e++;
    end
    assert_cnt++; if (e !== 0) begin fail_cnt++; $display("FAIL ign_no_second got %0d busy cycles want 0", e); end
  endtask

  task automatic test_async_reset();
    logic pre;
    repeat (2) @(negedge clk);
    bus.ld = 1'b1; bus.d = 8'h66; bus.opn = 1'b0; en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ld = 1'b0;
    repeat (17) @(negedge clk);
    pre = tx;
    assert_cnt++; if (pre !== model_bit(8'h66, 1'b0, 4)) begin fail_cnt++; $display("FAIL arst_pre_bit3 got %b want %b", pre, model_bit(8'h66, 1'b0, 4)); end
    #1 rst = 1'b0;
    #1;
    assert_cnt++; if (tx !== 1'b1)      begin fail_cnt++; $display("FAIL arst_tx got %b want 1", tx); end
    assert_cnt++; if (bus.rdy !== 1'b1) begin fail_cnt++; $display("FAIL arst_rdy got %b want 1", bus.rdy); end
    assert_cnt++; if (busy !== 1'b0)    begin fail_cnt++; $display("FAIL arst_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    drive_frame(8'h3C, 1'b1, 0, 0, 8'h00);
    assert_cnt++; if (done_cyc !== 45) begin fail_cnt++; $display("FAIL arst_after_done got %0d want 45", done_cyc); end
    assert_cnt++; if (tx_errs(8'h3C, 1'b1) !== 0) begin fail_cnt++; $display("FAIL arst_after_wave got %0d want 0", tx_errs(8'h3C, 1'b1)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic       o;
    repeat (2) @(negedge clk);
    drive_frame(8'hE1, 1'b0, 0, 0, 8'h00);
    b = 8'($urandom);
    o = 1'($urandom);
    drive_frame(b, o, 0, 0, 8'h00);
    assert_cnt++; if (done_cyc !== 45) begin fail_cnt++; $display("FAIL b2b_done got %0d want 45", done_cyc); end
    assert_cnt++; if (tx_errs(b, o) !== 0) begin fail_cnt++; $display("FAIL b2b_wave got %0d want 0", tx_errs(b, o)); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       o;
    int         md;
    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom);
      o  = 1'($urandom);
      md = ((i % 3) == 0) ? 2 : 0;
      if ((i % 2) == 1) repeat ($urandom_range(1, 5)) @(negedge clk);
      drive_frame(b, o, md, 0, 8'h00);
      assert_cnt++; if (done_cyc !== model_done()) begin fail_cnt++; $display("FAIL rnd%0d_done got %0d want %0d", i, done_cyc, model_done()); end
      assert_cnt++; if (tx_errs(b, o) !== 0) begin fail_cnt++; $display("FAIL rnd%0d_wave d=%h got %0d bad cycles want 0", i, b, tx_errs(b, o)); end
    end
  endtask

`ifdef SRT_TX_HOLD_EN
  task automatic test_hold();
    int   d1, d2, etx, ebusy;
    logic exp_b;
    repeat (2) @(negedge clk);
    d1 = -1; d2 = -1; etx = 0; ebusy = 0;
    bus.ld = 1'b1; bus.d = 8'h3C; bus.opn = 1'b0; en = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      bus.ld = 1'b0;
      if (k <= 44)      exp_b = model_bit(8'h3C, 1'b0, (k - 1) / DIV);
      else if (k <= 88) exp_b = model_bit(8'hC3, 1'b1, (k - 45) / DIV);
      else              exp_b = 1'b1;
      if (tx !== exp_b) etx++;
      if (busy !== (k <= 88)) ebusy++;
      if (done === 1'b1) begin
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (k == 20) begin
        assert_cnt++; if (bus.rdy !== 1'b0) begin fail_cnt++; $display("FAIL hold_rdy_full got %b want 0", bus.rdy); end
      end
      if (k == 45) begin
        assert_cnt++; if (bus.rdy !== 1'b1) begin fail_cnt++; $display("FAIL hold_rdy_freed got %b want 1", bus.rdy); end
      end
      if (k == 3)  begin bus.ld = 1'b1; bus.d = 8'hC3; bus.opn = 1'b1; end
      if (k == 10) begin bus.ld = 1'b1; bus.d = 8'h99; bus.opn = 1'b0; end
    end
    assert_cnt++; if (etx !== 0)   begin fail_cnt++; $display("FAIL hold_wave got %0d bad cycles want 0", etx); end
    assert_cnt++; if (ebusy !== 0) begin fail_cnt++; $display("FAIL hold_busy got %0d bad cycles want 0", ebusy); end
    assert_cnt++; if (d1 !== 45)   begin fail_cnt++; $display("FAIL hold_done1 got %0d want 45", d1); end
    assert_cnt++; if (d2 - d1 !== 44) begin fail_cnt++; $display("FAIL hold_done_gap got %0d want 44", d2 - d1); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_basic();
    test_parity();
    test_en_toggle();
`ifndef SRT_TX_HOLD_EN
    test_ld_ignored();
`endif
    test_async_reset();
    test_back_to_back();
    test_random();
`ifdef SRT_TX_HOLD_EN
    test_hold();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
